// File: rtl/datamem_pkg.sv
// datamem_pkg: shared FSM encoding, strobe constants and lane-mask helper for datamem_responder
package datamem_pkg;
  localparam int WAIT_W = 4;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } state_t;
  localparam logic [3:0] LANE_B0 = 4'b0001;
  localparam logic [3:0] LANE_B1 = 4'b0010;
  localparam logic [3:0] LANE_B2 = 4'b0100;
  localparam logic [3:0] LANE_B3 = 4'b1000;
  localparam logic [3:0] HALF_LO = 4'b0011;
  localparam logic [3:0] HALF_HI = 4'b1100;
  localparam logic [3:0] WORD    = 4'b1111;
  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    for (int i = 0; i < 4; i++) lane_mask[8*i+:8] = {8{s[i]}};
  endfunction
endpackage

// File: rtl/datamem_bytelane_ram.sv
// datamem_bytelane_ram: single-port 8-bit RAM bank with write enable and registered, write-first read
// Ports: clk; addr word index; we writes wdata; re loads rdata_q (new data when we is also set).
module datamem_bytelane_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic                  re,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata_q
);
  logic [7:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata_q <= we ? wdata : mem[addr];
  end
endmodule

// File: rtl/datamem_responder.sv
// datamem_responder: lane-strobed data-memory responder with configurable wait states
// Ports: Clk/Rst (sync, active-high); ReqValid/ReqReady handshake carrying Address, MemWrite,
// MemRead, WriteData; ReadData/ReadValid return lane-masked reads; Busy while in flight;
// Err pulses when a request carries both write and read strobes.
// Optional: define DATAMEM_WRITE_READBACK_EN to return the post-write word for pure writes.
module datamem_responder
  import datamem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [31:0] Address,
  input  logic [3:0]  MemWrite,
  input  logic [3:0]  MemRead,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        ReadValid,
  output logic        Busy,
  output logic        Err
);
  state_t                state_q, state_d;
  logic [WAIT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [3:0]            mw_q, mw_d, mr_q, mr_d, rmask_q, rmask_d;
  logic [31:0]           wd_q, wd_d, ram_rdata;
  logic                  rv_q, rv_d, err_q, err_d;
  logic                  accept, access, rb_go, rd_go;
  logic                  unused_addr;
  assign unused_addr = ^{Address[31:ADDR_WIDTH+2], Address[1:0]};
  assign ReqReady = state_q == IDLE && !Rst;
  assign accept   = ReqValid && ReqReady;
  // A reset arriving on the ACCESS edge cancels the access entirely.
  assign access   = state_q == ACCESS && !Rst;
`ifdef DATAMEM_WRITE_READBACK_EN
  assign rb_go = |mw_q && !(|mr_q);
`else
  assign rb_go = 1'b0;
`endif
  assign rd_go = access && ((|mr_q && !(|mw_q)) || rb_go);
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      rmask_q <= 4'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
      rmask_q <= rmask_d;
    end
    idx_q <= idx_d;
    mw_q  <= mw_d;
    mr_q  <= mr_d;
    wd_q  <= wd_d;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        cnt_d   = WAIT_W'(WAIT_STATES);
        state_d = WAIT_STATES == 0 ? ACCESS : WAIT;
      end
      WAIT: begin
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == WAIT_W'(1) ? ACCESS : WAIT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    idx_d   = accept ? Address[ADDR_WIDTH+1:2] : idx_q;
    mw_d    = accept ? MemWrite : mw_q;
    mr_d    = accept ? MemRead : mr_q;
    wd_d    = accept ? WriteData : wd_q;
    rv_d    = rd_go;
    err_d   = access && |mw_q && |mr_q;
    // The mask only moves on a read completion so ReadData holds between reads.
    rmask_d = rd_go ? (rb_go ? WORD : mr_q) : rmask_q;
  end
  for (genvar g = 0; g < 4; g++) begin : g_lane
    datamem_bytelane_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank (
      .clk    (Clk),
      .addr   (idx_q),
      .we     (access && mw_q[g]),
      .re     (rd_go),
      .wdata  (wd_q[8*g+:8]),
      .rdata_q(ram_rdata[8*g+:8])
    );
  end
  assign ReadData  = ram_rdata & lane_mask(rmask_q);
  assign ReadValid = rv_q;
  assign Busy      = state_q != IDLE;
  assign Err       = err_q;
endmodule

// File: tb/tb_datamem_responder.sv
// tb_datamem_responder: directed plus randomized checks of two responder instances (1 and 0 wait states)
module tb_datamem_responder;
  import datamem_pkg::*;
  localparam int AW  = 10;
  localparam int WS0 = 1;
  localparam int WS1 = 0;
  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [31:0] Address = '0, WriteData = '0;
  logic [3:0]  MemWrite = '0, MemRead = '0;
  logic [1:0]  rdy, rv, busy, err;
  logic [31:0] rdata [2];
  logic [31:0] mem [2][2**AW];
  logic [31:0] hold [2];
  int errors = 0;
  int checks = 0;
  always #5 Clk = ~Clk;
  datamem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(WS0)) u0 (
    .Clk(Clk), .Rst(Rst), .ReqValid(req_valid[0]), .ReqReady(rdy[0]), .Address(Address),
    .MemWrite(MemWrite), .MemRead(MemRead), .WriteData(WriteData), .ReadData(rdata[0]),
    .ReadValid(rv[0]), .Busy(busy[0]), .Err(err[0])
  );
  datamem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(WS1)) u1 (
    .Clk(Clk), .Rst(Rst), .ReqValid(req_valid[1]), .ReqReady(rdy[1]), .Address(Address),
    .MemWrite(MemWrite), .MemRead(MemRead), .WriteData(WriteData), .ReadData(rdata[1]),
    .ReadValid(rv[1]), .Busy(busy[1]), .Err(err[1])
  );
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input int s, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[u%0d] observed=%h expected=%h", tag, s, obs, exp);
    end
  endtask
  // Reference: word-array memory, byte-lane merge, expected response slot at accept+2+ws.
  task automatic txn(input int s, input logic [31:0] a, input logic [3:0] mw, input logic [3:0] mr,
                     input logic [31:0] wd);
    int ws;
    int idx;
    logic [31:0] old, nw, m;
    bit exp_rv, exp_err;
    ws  = s ? WS1 : WS0;
    idx = int'(a[AW+1:2]);
    old = mem[s][idx];
    nw  = old;
    m   = '0;
    for (int i = 0; i < 4; i++) begin
      if (mw[i]) nw[8*i+:8] = wd[8*i+:8];
      if (mr[i]) m[8*i+:8] = 8'hFF;
    end
    exp_err = mw != 0 && mr != 0;
    exp_rv  = mr != 0 && mw == 0;
    if (exp_rv) hold[s] = old & m;
`ifdef DATAMEM_WRITE_READBACK_EN
    if (mw != 0 && mr == 0) begin
      exp_rv  = 1'b1;
      hold[s] = nw;
    end
`endif
    mem[s][idx] = nw;
    chk("ready_at_req", s, 32'(rdy[s]), 32'd1);
    Address = a; MemWrite = mw; MemRead = mr; WriteData = wd; req_valid[s] = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    req_valid[s] = 1'b0;
    Address = $urandom; MemWrite = 4'($urandom); MemRead = 4'($urandom); WriteData = $urandom;
    for (int k = 1; k <= ws + 2; k++) begin
      if (k > 1) @(negedge Clk);
      chk("ready", s, 32'(rdy[s]), 32'(k == ws + 2));
      chk("busy", s, 32'(busy[s]), 32'(k < ws + 2));
      chk("read_valid", s, 32'(rv[s]), 32'(k == ws + 2 && exp_rv));
      chk("err", s, 32'(err[s]), 32'(k == ws + 2 && exp_err));
    end
    chk("read_data", s, rdata[s], hold[s]);
  endtask
  initial begin
    logic [31:0] a;
    hold[0] = '0;
    hold[1] = '0;
    repeat (2) @(negedge Clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_ready", s, 32'(rdy[s]), 32'd0);
      chk("rst_busy", s, 32'(busy[s]), 32'd0);
      chk("rst_rvalid", s, 32'(rv[s]), 32'd0);
      chk("rst_err", s, 32'(err[s]), 32'd0);
      chk("rst_rdata", s, rdata[s], 32'h0);
    end
    Rst = 1'b0;
    #1;
    chk("ready_after_rst", 0, 32'(rdy[0]), 32'd1);
    txn(0, 32'h40, WORD, 4'b0, 32'hDEADBEEF);
    txn(0, 32'h40, 4'b0, WORD, '0);
    chk("plan_word", 0, rdata[0], 32'hDEADBEEF);
    txn(0, 32'h40, LANE_B2, 4'b0, 32'h00AA0000);
    txn(0, 32'h40, 4'b0, WORD, '0);
    chk("plan_byte_merge", 0, rdata[0], 32'hDEAABEEF);
    txn(0, 32'h40, 4'b0, LANE_B2, '0);
    chk("plan_byte_read", 0, rdata[0], 32'h00AA0000);
    txn(0, 32'h40, 4'b0, HALF_HI, '0);
    chk("plan_half_hi", 0, rdata[0], 32'hDEAA0000);
    txn(0, 32'h40, 4'b0, HALF_LO, '0);
    chk("plan_half_lo", 0, rdata[0], 32'h0000BEEF);
    txn(0, 32'h40, LANE_B0, LANE_B0, 32'h00000011);
    chk("plan_conflict_hold", 0, rdata[0], 32'h0000BEEF);
    txn(0, 32'h40, 4'b0, LANE_B0, '0);
    chk("plan_conflict_write", 0, rdata[0], 32'h00000011);
    txn(0, 32'h40, 4'b0, 4'b0, 32'hFFFFFFFF);
    txn(0, 32'h40, 4'b0, 4'b0101, '0);
    chk("plan_noncontig", 0, rdata[0], 32'h00AA0011);
    txn(0, 32'h80, WORD, 4'b0, 32'h0);
    Address = 32'h80; MemWrite = WORD; MemRead = 4'b0; WriteData = 32'h12345678; req_valid[0] = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    req_valid[0] = 1'b0;
    chk("busy_in_wait", 0, 32'(busy[0]), 32'd1);
    Rst = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    chk("midrst_ready", 0, 32'(rdy[0]), 32'd0);
    chk("midrst_busy", 0, 32'(busy[0]), 32'd0);
    chk("midrst_rvalid", 0, 32'(rv[0]), 32'd0);
    chk("midrst_err", 0, 32'(err[0]), 32'd0);
    chk("midrst_rdata", 0, rdata[0], 32'h0);
    Rst = 1'b0;
    hold[0] = '0;
    hold[1] = '0;
    #1;
    txn(0, 32'h80, 4'b0, WORD, '0);
    chk("plan_discarded_write", 0, rdata[0], 32'h0);
    txn(1, 32'h40, WORD, 4'b0, 32'h01020304);
    txn(1, 32'h44, WORD, 4'b0, 32'hA5A55A5A);
    txn(1, 32'h40, 4'b0, WORD, '0);
    chk("b2b_first", 1, rdata[1], 32'h01020304);
    txn(1, 32'h44, 4'b0, WORD, '0);
    chk("b2b_second", 1, rdata[1], 32'hA5A55A5A);
    txn(1, 32'h48, WORD, 4'b0, 32'hCAFEF00D);
`ifdef DATAMEM_WRITE_READBACK_EN
    chk("plan_readback", 1, rdata[1], 32'hCAFEF00D);
`endif
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++) txn(s, 32'(i) << 2, WORD, 4'b0, $urandom);
      for (int n = 0; n < 40; n++) begin
        a = ($urandom & 32'hFFFFF003) | (32'($urandom_range(0, 15)) << 2);
        txn(s, a, 4'($urandom), 4'($urandom), $urandom);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
